adder_16bit: RTL and testbench

ADDER_16BIT -- requirements
Module: adder_16bit

---
 rtl/adder_16bit.sv | 221 ++++++++++++++++++++++
 tb/tb_adder_16bit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/adder_16bit.sv
// ---------------------------------------------------------------------------
// adder_16bit
// 16-bit unsigned registered adder with no carry-in.
//
// Datapath: four 4-bit carry-lookahead groups. Each group forms per-bit
// generate/propagate and group G/P. A second-level lookahead unit produces
// the group carries c4, c8, c12 and the final carry c16. No carry ripples
// across more than 4 bits.
//
// Build option: define ADDER_16BIT_PIPE_EN to add an extra pipeline stage.
//   Stage 1 registers the low byte of the sum, c8, the high operand bytes
//   and valid. Stage 2 computes the high byte.
//   Latency is 2 cycles with the macro and 1 cycle without it.
//   Throughput is one operand pair per cycle in both builds, and the ports
//   are the same in both builds.
//
// Result registers load only for valid operands and hold otherwise.
// out_valid is in_valid delayed by the latency.
// rst_n clears every register asynchronously. Any operation still in the
// pipeline when reset asserts is dropped.
// ---------------------------------------------------------------------------
module adder_16bit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        cout,
    output logic        out_valid
);

    // Sum bits of one 4-bit lookahead group; the internal carries are
    // expanded from g/p, so there is no ripple inside the group.
    function automatic logic [3:0] cla4_sum(input logic [3:0] g,
                                            input logic [3:0] p,
                                            input logic       cin);
        logic [3:0] c;
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        return p ^ c;
    endfunction

    // Group generate of a 4-bit block.
    function automatic logic cla4_g(input logic [3:0] g,
                                    input logic [3:0] p);
        return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);
    endfunction

    // Group propagate of a 4-bit block.
    function automatic logic cla4_p(input logic [3:0] p);
        return &p;
    endfunction

`ifdef ADDER_16BIT_PIPE_EN

    // ---------------- two-stage build ----------------
    logic [7:0] g_lo_s;
    logic [7:0] p_lo_s;
    logic       gg0_s;
    logic       gg1_s;
    logic       gp1_s;
    logic       c4_s;
    logic       c8_s;
    logic [7:0] sum_lo_s;

    logic [7:0] sum_lo_r;
    logic       c8_r;
    logic [7:0] a_hi_r;
    logic [7:0] b_hi_r;
    logic       v1_r;

    logic [7:0] g_hi_s;
    logic [7:0] p_hi_s;
    logic       gg2_s;
    logic       gp2_s;
    logic       gg3_s;
    logic       gp3_s;
    logic       c12_s;
    logic       c16_s;
    logic [7:0] sum_hi_s;

    // Stage 1 datapath: groups 0 and 1 and the lookahead for c4 and c8.
    // Carry-in is zero, so c4 is just the group-0 generate.
    always_comb begin
        g_lo_s   = a[7:0] & b[7:0];
        p_lo_s   = a[7:0] ^ b[7:0];
        gg0_s    = cla4_g(g_lo_s[3:0], p_lo_s[3:0]);
        gg1_s    = cla4_g(g_lo_s[7:4], p_lo_s[7:4]);
        gp1_s    = cla4_p(p_lo_s[7:4]);
        c4_s     = gg0_s;
        c8_s     = gg1_s | (gp1_s & gg0_s);
        sum_lo_s = {cla4_sum(g_lo_s[7:4], p_lo_s[7:4], c4_s),
                    cla4_sum(g_lo_s[3:0], p_lo_s[3:0], 1'b0)};
    end

    // Stage 1 registers. Data loads only for valid operands; valid always
    // advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_lo_r <= 8'h00;
            c8_r     <= 1'b0;
            a_hi_r   <= 8'h00;
            b_hi_r   <= 8'h00;
            v1_r     <= 1'b0;
        end else begin
            v1_r <= in_valid;
            if (in_valid) begin
                sum_lo_r <= sum_lo_s;
                c8_r     <= c8_s;
                a_hi_r   <= a[15:8];
                b_hi_r   <= b[15:8];
            end else begin
                sum_lo_r <= sum_lo_r;
                c8_r     <= c8_r;
                a_hi_r   <= a_hi_r;
                b_hi_r   <= b_hi_r;
            end
        end
    end

    // Stage 2 datapath: groups 2 and 3, with c12 and c16 looked ahead from
    // the registered c8.
    always_comb begin
        g_hi_s   = a_hi_r & b_hi_r;
        p_hi_s   = a_hi_r ^ b_hi_r;
        gg2_s    = cla4_g(g_hi_s[3:0], p_hi_s[3:0]);
        gp2_s    = cla4_p(p_hi_s[3:0]);
        gg3_s    = cla4_g(g_hi_s[7:4], p_hi_s[7:4]);
        gp3_s    = cla4_p(p_hi_s[7:4]);
        c12_s    = gg2_s | (gp2_s & c8_r);
        c16_s    = gg3_s | (gp3_s & gg2_s) | (gp3_s & gp2_s & c8_r);
        sum_hi_s = {cla4_sum(g_hi_s[7:4], p_hi_s[7:4], c12_s),
                    cla4_sum(g_hi_s[3:0], p_hi_s[3:0], c8_r)};
    end

    // Output registers. They load when stage 1 holds a valid operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= 16'h0000;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= v1_r;
            if (v1_r) begin
                sum  <= {sum_hi_s, sum_lo_r};
                cout <= c16_s;
            end else begin
                sum  <= sum;
                cout <= cout;
            end
        end
    end

`else

    // ---------------- single-stage build ----------------
    logic [15:0] g_s;
    logic [15:0] p_s;
    logic        gg0_s;
    logic        gg1_s;
    logic        gg2_s;
    logic        gg3_s;
    logic        gp1_s;
    logic        gp2_s;
    logic        gp3_s;
    logic        c4_s;
    logic        c8_s;
    logic        c12_s;
    logic        c16_s;
    logic [15:0] sum_s;

    // Full 16-bit lookahead: per-group G/P, then the second-level unit
    // produces c4, c8, c12 and c16. Carry-in is zero, so group-0 propagate
    // is never needed.
    always_comb begin
        g_s   = a & b;
        p_s   = a ^ b;
        gg0_s = cla4_g(g_s[3:0],   p_s[3:0]);
        gg1_s = cla4_g(g_s[7:4],   p_s[7:4]);
        gg2_s = cla4_g(g_s[11:8],  p_s[11:8]);
        gg3_s = cla4_g(g_s[15:12], p_s[15:12]);
        gp1_s = cla4_p(p_s[7:4]);
        gp2_s = cla4_p(p_s[11:8]);
        gp3_s = cla4_p(p_s[15:12]);
        c4_s  = gg0_s;
        c8_s  = gg1_s | (gp1_s & gg0_s);
        c12_s = gg2_s | (gp2_s & gg1_s) | (gp2_s & gp1_s & gg0_s);
        c16_s = gg3_s | (gp3_s & gg2_s) | (gp3_s & gp2_s & gg1_s)
              | (gp3_s & gp2_s & gp1_s & gg0_s);
        sum_s = {cla4_sum(g_s[15:12], p_s[15:12], c12_s),
                 cla4_sum(g_s[11:8],  p_s[11:8],  c8_s),
                 cla4_sum(g_s[7:4],   p_s[7:4],   c4_s),
                 cla4_sum(g_s[3:0],   p_s[3:0],   1'b0)};
    end

    // Output registers. They load for valid operands and hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum       <= 16'h0000;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                sum  <= sum_s;
                cout <= c16_s;
            end else begin
                sum  <= sum;
                cout <= cout;
            end
        end
    end

`endif

endmodule

// File: tb/tb_adder_16bit.sv
// ---------------------------------------------------------------------------
// tb_adder_16bit
// Self-checking bench for adder_16bit.
// The reference model is plain 17-bit arithmetic. Each operand pair goes
// through a queue whose depth equals the latency. The expected result holds
// across cycles where the input was not valid.
// Compile with the same ADDER_16BIT_PIPE_EN setting as the RTL.
// ---------------------------------------------------------------------------
module tb_adder_16bit;

`ifdef ADDER_16BIT_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        clk;
    logic        clk_en;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        cout;
    logic        out_valid;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic        v;
        logic [16:0] s;
    } ent_t;

    ent_t        q[$];
    logic [16:0] held;

    adder_16bit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
    );

    // Clock toggles only while clk_en is set, so reset can be applied with
    // the clock stopped.
    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    // Stops a run that never reaches the end of the stimulus.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Clears the model: the pipeline holds no valid entries and the
    // expected result is zero.
    task automatic model_reset();
        q.delete();
        for (int i = 0; i < LAT; i++) q.push_back('{v: 1'b0, s: 17'h0});
        held = 17'h0;
    endtask

    // Advances one clock edge, updates the model, then checks out_valid and
    // {cout,sum}.
    task automatic step(input string tag);
        ent_t e;
        ent_t d;
        @(posedge clk);
        #1;
        e.v = in_valid;
        e.s = 17'(a) + 17'(b);
        q.push_back(e);
        d = q.pop_front();
        if (q[0].v) held = q[0].s;
        check_eq({tag, "_valid"}, {31'h0, out_valid}, {31'h0, q[0].v});
        check_eq({tag, "_sum"}, {15'h0, cout, sum}, {15'h0, held});
    endtask

    task automatic drive(input logic v, input logic [15:0] x,
                         input logic [15:0] y, input string tag);
        in_valid = v;
        a        = x;
        b        = y;
        step(tag);
    endtask

    task automatic check_zero(input string tag);
        check_eq(tag, {14'h0, out_valid, cout, sum}, 32'h0);
    endtask

    logic [15:0] corners [0:5];

    initial begin
        corners[0] = 16'hFFFF;
        corners[1] = 16'h0000;
        corners[2] = 16'h0001;
        corners[3] = 16'h00FF;
        corners[4] = 16'h8000;
        corners[5] = 16'h7FFF;

        // Reset with no clock running: the outputs must clear at once.
        clk_en   = 1'b0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 16'h0000;
        b        = 16'h0000;
        #2;
        check_zero("reset_noclk");
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_clk");
        model_reset();
        rst_n = 1'b1;

        // First valid input after release, then idle cycles: the result
        // must hold and out_valid must be a single pulse.
        drive(1'b1, 16'd100, 16'd200, "basic");
        for (int i = 0; i < 3; i++) drive(1'b0, 16'h1234, 16'h4321, "basic_idle");

        // Carry boundaries, separated by idle cycles.
        drive(1'b1, 16'hFFFF, 16'h0001, "wrap1");
        drive(1'b0, 16'h0000, 16'h0000, "wrap1_idle");
        drive(1'b1, 16'hFFFF, 16'hFFFF, "wrap2");
        drive(1'b0, 16'h0000, 16'h0000, "wrap2_idle");
        drive(1'b1, 16'h00FF, 16'h0001, "byte_carry");
        drive(1'b0, 16'h0000, 16'h0000, "byte_idle");
        drive(1'b1, 16'h0000, 16'h0000, "zero");
        for (int i = 0; i < LAT + 1; i++) drive(1'b0, 16'hAAAA, 16'h5555, "zero_idle");

        // Back-to-back operands with in_valid held high.
        for (int i = 0; i < 300; i++) drive(1'b1, 16'(i), 16'(i), "b2b");
        for (int i = 0; i < LAT + 1; i++) drive(1'b0, 16'h0000, 16'h0000, "b2b_idle");

        // Random valid pattern and operands, with some corner values mixed in.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] x;
            logic [15:0] y;
            x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)]
                                            : 16'($urandom());
            y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)]
                                            : 16'($urandom());
            drive(1'($urandom_range(0, 3) != 0), x, y, "rand");
        end

        // Reset mid-flight. One pair is clocked in, a second pair is on the
        // inputs, then reset asserts between edges.
        drive(1'b1, 16'h8000, 16'h8000, "flight_load");
        in_valid = 1'b1;
        a        = 16'h8000;
        b        = 16'h8000;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("flight_rst_imm");
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("flight_rst_hold");
        model_reset();
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 1; i++) drive(1'b0, 16'h8000, 16'h8000, "flight_idle");
        drive(1'b1, 16'h1357, 16'hECA9, "flight_fresh");
        for (int i = 0; i < LAT + 1; i++) drive(1'b0, 16'h0000, 16'h0000, "flight_end");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
